// File: rtl/code_lock_ctrl.sv
// Keypad code lock: collects CODE_LEN digits, compares with code, unlocks with retry lockout and auto-relock; CODE_LOCK_ENTRY_TIMEOUT_EN adds an idle timeout in INPUT.
// Latency: last digit sampled at edge n -> VERIFY after n -> UNLOCKED/ERROR/LOCKOUT after n+1.
// Backpressure: none; keys outside LOCKED/INPUT and lock_cmd outside UNLOCKED are dropped.
module code_lock_ctrl #(
  parameter int DIGIT_W        = 4,
  parameter int CODE_LEN       = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int ENTRY_TIMEOUT  = 32,
  localparam int CNT_W = $clog2(CODE_LEN + 1),
  localparam int TRY_W = $clog2(MAX_TRIES + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         key_valid,
  input  logic [DIGIT_W-1:0]           key_digit,
  input  logic [CODE_LEN*DIGIT_W-1:0]  code,
  input  logic                         lock_cmd,
  output logic [2:0]                   state,
  output logic                         unlocked,
  output logic                         error,
  output logic                         lockout,
  output logic [CNT_W-1:0]             digit_count,
  output logic [TRY_W-1:0]             tries_left
);

  localparam int T_AB    = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TMR_MAX = (T_AB > ENTRY_TIMEOUT) ? T_AB : ENTRY_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_LOCKED   = 3'b000,
    S_INPUT    = 3'b001,
    S_VERIFY   = 3'b010,
    S_ERROR    = 3'b011,
    S_UNLOCKED = 3'b100,
    S_LOCKOUT  = 3'b101
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [TRY_W-1:0]            tries_q, tries_d;
  logic [CODE_LEN*DIGIT_W-1:0] buf_q, buf_d;
  logic [TMR_W-1:0]            timer_q, timer_d;
  logic                        wr_en;
  logic [CNT_W-1:0]            wr_slot;
  logic                        fail_attempt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOCKED;
      cnt_q   <= '0;
      tries_q <= TRY_W'(MAX_TRIES);
      buf_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tries_q <= tries_d;
      buf_q   <= buf_d;
      timer_q <= timer_d;
    end
  end

  // The single timer is zero in every state that does not advance it, so it restarts on entry.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tries_d      = tries_q;
    buf_d        = buf_q;
    timer_d      = '0;
    wr_en        = 1'b0;
    wr_slot      = '0;
    fail_attempt = 1'b0;

    case (state_q)
      S_LOCKED: begin
        if (key_valid) begin
          wr_en   = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = (CODE_LEN == 1) ? S_VERIFY : S_INPUT;
        end
      end
      S_INPUT: begin
        if (key_valid) begin
          wr_en   = 1'b1;
          wr_slot = cnt_q;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CODE_LEN - 1)) state_d = S_VERIFY;
        end
`ifdef CODE_LOCK_ENTRY_TIMEOUT_EN
        else if (timer_q == TMR_W'(ENTRY_TIMEOUT - 1)) begin
          fail_attempt = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
`endif
      end
      S_VERIFY: begin
        if (buf_q == code) begin
          state_d = S_UNLOCKED;
          tries_d = TRY_W'(MAX_TRIES);
          cnt_d   = '0;
        end else begin
          fail_attempt = 1'b1;
        end
      end
      S_ERROR: state_d = S_LOCKED;
      S_UNLOCKED: begin
        if (lock_cmd || timer_q == TMR_W'(UNLOCK_CYCLES - 1)) state_d = S_LOCKED;
        else timer_d = timer_q + TMR_W'(1);
      end
      S_LOCKOUT: begin
        if (timer_q == TMR_W'(LOCKOUT_CYCLES - 1)) begin
          state_d = S_LOCKED;
          tries_d = TRY_W'(MAX_TRIES);
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = S_LOCKED;
        cnt_d   = '0;
      end
    endcase

    // Shared by a wrong code and an entry timeout.
    if (fail_attempt) begin
      cnt_d = '0;
      if (tries_q > TRY_W'(1)) begin
        tries_d = tries_q - TRY_W'(1);
        state_d = S_ERROR;
      end else begin
        tries_d = '0;
        state_d = S_LOCKOUT;
      end
    end

    // Slot 0 lives in the MSBs so the buffer lines up with code.
    for (int i = 0; i < CODE_LEN; i++) begin
      if (wr_en && wr_slot == CNT_W'(i))
        buf_d[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = key_digit;
    end
  end

  assign state       = state_q;
  assign unlocked    = (state_q == S_UNLOCKED);
  assign error       = (state_q == S_ERROR);
  assign lockout     = (state_q == S_LOCKOUT);
  assign digit_count = cnt_q;
  assign tries_left  = tries_q;

endmodule
